// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the conv1 weight-load path.
package cnn_pkg;

    localparam int unsigned NUM_KERNELS = 8;
    localparam int unsigned KTAPS       = 9;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ROM_DEPTH   = NUM_KERNELS * KTAPS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_e;

endpackage

// File: rtl/kernel_tap_regs.sv
// KTAPS x DATA_W register bank written one slot at a time, exposed as a flat bus.
module kernel_tap_regs #(
    parameter int unsigned KTAPS  = 9,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]       din,
    output logic [KTAPS*DATA_W-1:0] flat
);

    logic [DATA_W-1:0] regs_q [KTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < KTAPS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (32'(idx) < KTAPS)) begin
            regs_q[idx] <= din;
        end
    end

    always_comb begin
        flat = '0;
        for (int unsigned i = 0; i < KTAPS; i++) begin
            flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/kernel_load_ctrl.sv
// Sweeps the conv1 weight ROM kernel by kernel and presents each 3x3 tap set
// to the convolution engine behind a valid/ready handshake.
module kernel_load_ctrl #(
    parameter int unsigned NUM_KERNELS = cnn_pkg::NUM_KERNELS,
    parameter int unsigned KTAPS       = cnn_pkg::KTAPS,
    parameter int unsigned DATA_W      = cnn_pkg::DATA_W,
    parameter int unsigned ADDR_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [KTAPS*DATA_W-1:0] k_flat,
    output logic [2:0]              k_id,
    output logic                    k_valid,
    input  logic                    k_ready,
    output logic                    busy,
    output logic                    sweep_done
);
    import cnn_pkg::*;

    localparam int unsigned TAP_W = $clog2(KTAPS);

    state_e            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        k_id_q, k_id_d;
    logic              done_q, done_d;
    logic              cap_en_q;
    logic [TAP_W-1:0]  cap_slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            base_q     <= '0;
            k_id_q     <= '0;
            done_q     <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            base_q     <= base_d;
            k_id_q     <= k_id_d;
            done_q     <= done_d;
            // ROM answers one cycle later, so the slot index trails the read by one
            cap_en_q   <= rom_en;
            cap_slot_q <= tap_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        base_d  = base_q;
        k_id_d  = k_id_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    tap_d   = '0;
                    base_d  = '0;
                    k_id_d  = '0;
                end
            end
            FETCH: begin
                if (tap_q == TAP_W'(KTAPS - 1)) begin
                    state_d = DRAIN;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            DRAIN: state_d = PRESENT;
            PRESENT: begin
                if (k_ready) begin
                    if (k_id_q == 3'(NUM_KERNELS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        tap_d   = '0;
                        k_id_d  = k_id_q + 1'b1;
                        base_d  = base_q + ADDR_W'(KTAPS);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_en     = (state_q == FETCH);
    assign rom_addr   = rom_en ? (base_q + ADDR_W'(tap_q)) : '0;
    assign k_valid    = (state_q == PRESENT);
    assign busy       = (state_q != IDLE);
    assign k_id       = k_id_q;
    assign sweep_done = done_q;

    kernel_tap_regs #(
        .KTAPS  (KTAPS),
        .DATA_W (DATA_W),
        .IDX_W  (TAP_W)
    ) u_taps (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cap_en_q),
        .idx   (cap_slot_q),
        .din   (rom_data),
        .flat  (k_flat)
    );

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Directed bench for kernel_load_ctrl with a 1-cycle ROM model (mem[a] = a + 8'h10).
module tb_kernel_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rom_en;
    logic [6:0]  rom_addr;
    logic [7:0]  rom_data = '0;
    logic [71:0] k_flat;
    logic [2:0]  k_id;
    logic        k_valid;
    logic        k_ready;
    logic        busy;
    logic        sweep_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0;
    int max_addr = 0;
    logic addr_bad = 1'b0;
    logic held;

    kernel_load_ctrl #(
        .NUM_KERNELS (8),
        .KTAPS       (9),
        .DATA_W      (8),
        .ADDR_W      (7)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .k_flat     (k_flat),
        .k_id       (k_id),
        .k_valid    (k_valid),
        .k_ready    (k_ready),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_en) rom_data <= {1'b0, rom_addr} + 8'h10;
    end

    always @(negedge clk) begin
        if (rom_en && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        if (!rom_en && rom_addr != 7'd0) addr_bad = 1'b1;
    end

    function automatic logic [71:0] exp_kernel(input int k);
        logic [71:0] v;
        v = '0;
        for (int t = 0; t < 9; t++) v[t*8 +: 8] = 8'(k*9 + t + 16);
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Waits (bounded) for k_valid, then checks wait length, k_id and taps.
    task automatic present(input int k, input int exp_wait);
        int n;
        n = 0;
        while (k_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check($sformatf("k%0d_latency", k), 128'(n), 128'(exp_wait));
        check($sformatf("k%0d_id", k), 128'(k_id), 128'(k));
        check($sformatf("k%0d_flat", k), 128'(k_flat), 128'(exp_kernel(k)));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        k_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rom_en", 128'(rom_en), 128'(0));
        check("rst_kvalid", 128'(k_valid), 128'(0));
        check("rst_kflat", 128'(k_flat), 128'(0));
        check("rst_done", 128'(sweep_done), 128'(0));
        rst_n = 1'b1;
        step();

        // First kernel: address walk and 10-cycle latency
        start   = 1'b1;
        k_ready = 1'b1;
        step();
        start = 1'b0;
        c0 = cyc;
        check("e0_busy", 128'(busy), 128'(1));
        check("e0_rom_en", 128'(rom_en), 128'(1));
        check("e0_addr", 128'(rom_addr), 128'(0));
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("k0_addr%0d", n), 128'(rom_addr), 128'(n));
        end
        step();
        check("drain_rom_en", 128'(rom_en), 128'(0));
        check("drain_addr", 128'(rom_addr), 128'(0));
        check("drain_kvalid", 128'(k_valid), 128'(0));
        present(0, 1);

        // Rest of the sweep with k_ready held high
        for (int k = 1; k < 8; k++) begin
            step();
            present(k, 10);
        end
        step();
        check("sweep_done_pulse", 128'(sweep_done), 128'(1));
        check("sweep_cycles", 128'(cyc - c0), 128'(88));
        check("end_busy", 128'(busy), 128'(0));
        check("end_kvalid", 128'(k_valid), 128'(0));

        // Start in the sweep_done cycle is accepted
        start   = 1'b1;
        k_ready = 1'b0;
        step();
        start = 1'b0;
        check("restart_done_low", 128'(sweep_done), 128'(0));
        check("restart_busy", 128'(busy), 128'(1));
        check("restart_kid", 128'(k_id), 128'(0));
        check("restart_addr", 128'(rom_addr), 128'(0));
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_fetch_addr", 128'(rom_addr), 128'(2));
        check("start_in_fetch_kid", 128'(k_id), 128'(0));
        present(0, 8);

        // Stall 20 cycles in PRESENT with a stray start pulse
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            step();
            held &= (k_valid === 1'b1) && (k_id === 3'd0) && (k_flat === exp_kernel(0))
                    && (rom_en === 1'b0) && (busy === 1'b1);
        end
        start = 1'b0;
        check("stall_held", 128'(held), 128'(1));
        k_ready = 1'b1;
        step();
        check("resume_kvalid", 128'(k_valid), 128'(0));
        check("resume_rom_en", 128'(rom_en), 128'(1));
        check("resume_addr", 128'(rom_addr), 128'(9));
        check("resume_kid", 128'(k_id), 128'(1));

        // k_ready already high: one kernel per handshake, no skipped ids
        present(1, 10);
        step();
        present(2, 10);
        step();
        check("k3_addr0", 128'(rom_addr), 128'(27));
        repeat (4) step();
        check("k3_addr4", 128'(rom_addr), 128'(31));

        // Asynchronous reset mid-fetch
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_rom_en", 128'(rom_en), 128'(0));
        check("arst_addr", 128'(rom_addr), 128'(0));
        check("arst_kid", 128'(k_id), 128'(0));
        check("arst_kflat", 128'(k_flat), 128'(0));
        check("arst_kvalid", 128'(k_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_addr", 128'(rom_addr), 128'(0));
        check("post_rst_kid", 128'(k_id), 128'(0));
        present(0, 10);

        check("max_rom_addr", 128'(max_addr), 128'(71));
        check("addr_zero_when_idle", 128'(addr_bad), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
